mops_sdo_responder: RTL and testbench
=====================================

Name: mops_sdo_responder

Overview:
Node-side CANopen SDO server that emulates one MOPS chip on a single MOPSHUB CAN bus. It is the responder for the SDO requests that MOPSHUB issues downlink. It accepts decoded 76-bit request frames from the bus decoder, executes expedited upload/download on a small object dictionary, and fetches ADC channels through a handshake to an ADC model. It returns 76-bit response frames to the bus encoder. The data generator instantiates one per emulated bus.

Parameters:
DEVICE_TYPE, 32'h0000_0191, read-only value of object 0x1000 sub0
N_ADC_CH, 32, number of ADC subindices (1..N_ADC_CH) under object 0x2400
ADC_TIMEOUT, 16'd1000, clk_40_m cycles to wait for adc_ack before aborting

Ports:
clk_40_m  in  1  clock
rst  in  1  synchronous reset, active low
node_id  in  7  CANopen node ID of this emulated MOPS
rx_frame  in  76  request frame: [75] reserved, [74:64] COB-ID, [63:0] payload, byte0=[63:56]
rx_valid  in  1  rx_frame valid
rx_ready  out  1  responder can accept a frame
tx_frame  out  76  response frame, same format
tx_valid  out  1  tx_frame valid
tx_ready  in  1  encoder accepts tx_frame
adc_req  out  1  ADC conversion request
adc_ch  out  5  requested channel (subindex-1)
adc_ack  in  1  ADC result valid (one-cycle pulse)
adc_val  in  12  ADC result
user_reg  out  32  object 0x2200 sub0 contents
sdo_cnt  out  16  number of accepted matching requests

Behaviour:
- Reset (rst=0 at posedge): state IDLE; rx_ready=1, tx_valid=0, tx_frame=0, adc_req=0, adc_ch=0, user_reg=0, sdo_cnt=0. A reset mid-transaction drops the transaction without a response.
- Accept: a frame is accepted only when rx_valid&&rx_ready, and rx_ready=1 only in IDLE. The frame is captured and rx_ready drops the next cycle.
- Filter: a captured COB-ID != 0x600+node_id means the frame is discarded and the state returns to IDLE (rx_ready=1 again on the following cycle). sdo_cnt is unchanged. Bit [75] is ignored.
- sdo_cnt increments once per matching frame. It wraps 0xFFFF->0x0000.
- Payload fields: cmd=byte0; index={byte2,byte1}; sub=byte3; data={byte7,byte6,byte5,byte4}.
- States:
  - IDLE: wait for an accepted frame.
  - DECODE: one cycle after capture; choose the response or go to ADC_WAIT.
  - ADC_WAIT: adc_req=1 and adc_ch=sub-1. Hold until adc_ack or until ADC_TIMEOUT cycles have elapsed.
  - SEND: tx_valid=1, tx_frame stable until tx_ready. IDLE on the cycle after tx_valid&&tx_ready.
- Response format: COB-ID 0x580+node_id, [75]=0. byte1..3 echo index/sub. Unused data bytes are 0.
- Decode rules, in priority order:
  - cmd==0x40 (upload), index 0x1000 sub0: 0x43 with data=DEVICE_TYPE.
  - cmd==0x40, index 0x2200 sub0: 0x43 with data=user_reg.
  - cmd==0x40, index 0x2400 sub 1..N_ADC_CH: go to ADC_WAIT. On adc_ack: 0x43 with data={20'h0,adc_val}, adc_req=0 in the same cycle as SEND entry.
  - cmd in {0x23,0x27,0x2B,0x2F} (expedited download), index 0x2200 sub0: user_reg<=data masked to the size given by cmd bits[3:2] (0x2F: byte, 0x2B: 16-bit, 0x27: 24-bit, 0x23: 32-bit, zero-extended). Response 0x60 with data 0.
  - Download to 0x1000 or 0x2400: abort code 0x06010002.
  - Index 0x2400 with sub 0 or sub>N_ADC_CH: abort 0x06090011.
  - Any other index: abort 0x06020000.
  - Any other cmd: abort 0x05040001. The cmd check comes before the index check.
  - ADC timeout: adc_req=0, abort 0x08000000.
- Abort frame: byte0=0x80, bytes4..7 = code, little-endian.
- Latency:
  - Non-ADC path: tx_valid rises 2 cycles after the accepting edge (capture, DECODE, SEND).
  - ADC path: SEND is entered on the cycle after adc_ack is sampled.
- adc_ack outside ADC_WAIT is ignored. adc_ack arriving in the same cycle as the timeout expiry: the ack wins.
- tx_ready held low: the responder stalls in SEND indefinitely with a stable frame, and rx_ready stays 0.

Test Plan:
- node_id=0x05; upload 0x1000 sub0 (COB 0x605, payload 40 00 10 00 00 00 00 00) -> COB 0x585, payload 43 00 10 00 91 01 00 00, tx_valid 2 cycles after acceptance, sdo_cnt=1.
- Download 0x2B to 0x2200 data 0xBEEF, then upload 0x2200 -> responses 60 00 22 00 00.. and 43 00 22 00 EF BE 00 00; user_reg=0x0000BEEF.
- Upload 0x2400 sub 0x03, ADC model acks after 10 cycles with 0xABC -> adc_ch=2, adc_req high until the ack, response 43 00 24 03 BC 0A 00 00.
- Upload 0x2400 sub 0x03 with no ack -> after 1000 cycles adc_req drops and the response is 80 00 24 03 00 00 00 08; sub 0x21 -> abort code 0x06090011.
- Frame with COB 0x606 -> no tx_valid, sdo_cnt unchanged, rx_ready back to 1 within 2 cycles; cmd 0x55 -> abort 0x05040001.
- Hold tx_ready=0 for 50 cycles during SEND, pulse rst low mid-ADC_WAIT -> frame stable while stalled; after reset all outputs at their reset values and no response is sent.

Source files
------------

// File: rtl/mops_sdo_responder_if.sv
// Request/response frame and ADC handshake bundle between a MOPS SDO responder
// and its bus decoder/encoder and ADC model.
interface mops_sdo_responder_if;
  logic [75:0] rx_frame;
  logic        rx_valid;
  logic        rx_ready;
  logic [75:0] tx_frame;
  logic        tx_valid;
  logic        tx_ready;
  logic        adc_req;
  logic [4:0]  adc_ch;
  logic        adc_ack;
  logic [11:0] adc_val;

  modport master (
    output rx_frame, rx_valid, tx_ready, adc_ack, adc_val,
    input  rx_ready, tx_frame, tx_valid, adc_req, adc_ch
  );

  modport slave (
    input  rx_frame, rx_valid, tx_ready, adc_ack, adc_val,
    output rx_ready, tx_frame, tx_valid, adc_req, adc_ch
  );
endinterface

// File: rtl/mops_sdo_responder.sv
// CANopen SDO server emulating one MOPS chip: expedited upload/download on a
// small object dictionary, with ADC channels fetched through a req/ack handshake.
module mops_sdo_responder #(
  parameter logic [31:0] DEVICE_TYPE = 32'h0000_0191,
  parameter int unsigned N_ADC_CH    = 32,
  parameter logic [15:0] ADC_TIMEOUT = 16'd1000
) (
  input  logic                     clk_40_m,
  input  logic                     rst,
  input  logic [6:0]               node_id,
  mops_sdo_responder_if.slave      bus,
  output logic [31:0]              user_reg,
  output logic [15:0]              sdo_cnt
);

  localparam logic [31:0] ABORT_CMD     = 32'h0504_0001;
  localparam logic [31:0] ABORT_RO      = 32'h0601_0002;
  localparam logic [31:0] ABORT_NOOBJ   = 32'h0602_0000;
  localparam logic [31:0] ABORT_NOSUB   = 32'h0609_0011;
  localparam logic [31:0] ABORT_TIMEOUT = 32'h0800_0000;

  // CAPTURE is the cycle between acceptance and DECODE where the COB-ID filter runs
  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_DECODE, S_ADC_WAIT, S_SEND
  } state_t;

  state_t      state;
  logic [74:0] rx_q;
  logic [15:0] tmo_cnt;

  logic [7:0]  cmd;
  logic [15:0] idx;
  logic [7:0]  sub;
  logic [31:0] wdata;
  logic [31:0] wmask;
  logic        is_upload;
  logic        is_dnload;
  logic        sub_ok;
  logic [7:0]  dec_cmd;
  logic [31:0] dec_data;
  logic        dec_adc;
  logic        dec_wr;
  logic [10:0] req_cob;

  assign req_cob = 11'h600 + {4'h0, node_id};

  function automatic logic [75:0] mk_frame(input logic [6:0] nid, input logic [7:0] c,
                                           input logic [23:0] echo, input logic [31:0] d);
    return {1'b0, 11'h580 + {4'h0, nid}, c, echo,
            d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  always_comb begin
    cmd       = rx_q[63:56];
    idx       = {rx_q[47:40], rx_q[55:48]};
    sub       = rx_q[39:32];
    wdata     = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
    is_upload = (cmd == 8'h40);
    is_dnload = (cmd == 8'h23) || (cmd == 8'h27) || (cmd == 8'h2B) || (cmd == 8'h2F);
    sub_ok    = (sub != 8'h00) && (32'(sub) <= N_ADC_CH);
    case (cmd[3:2])
      2'b11:   wmask = 32'h0000_00FF;
      2'b10:   wmask = 32'h0000_FFFF;
      2'b01:   wmask = 32'h00FF_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
    dec_cmd  = 8'h80;
    dec_data = ABORT_NOOBJ;
    dec_adc  = 1'b0;
    dec_wr   = 1'b0;
    if (!is_upload && !is_dnload) begin
      dec_data = ABORT_CMD;
    end else if (is_upload && idx == 16'h1000 && sub == 8'h00) begin
      dec_cmd  = 8'h43;
      dec_data = DEVICE_TYPE;
    end else if (is_upload && idx == 16'h2200 && sub == 8'h00) begin
      dec_cmd  = 8'h43;
      dec_data = user_reg;
    end else if (is_upload && idx == 16'h2400 && sub_ok) begin
      dec_adc  = 1'b1;
    end else if (is_dnload && idx == 16'h2200 && sub == 8'h00) begin
      dec_cmd  = 8'h60;
      dec_data = '0;
      dec_wr   = 1'b1;
    end else if (is_dnload && (idx == 16'h1000 || idx == 16'h2400)) begin
      dec_data = ABORT_RO;
    end else if (idx == 16'h2400) begin
      dec_data = ABORT_NOSUB;
    end
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state        <= S_IDLE;
      rx_q         <= '0;
      tmo_cnt      <= '0;
      bus.rx_ready <= 1'b1;
      bus.tx_valid <= 1'b0;
      bus.tx_frame <= '0;
      bus.adc_req  <= 1'b0;
      bus.adc_ch   <= '0;
      user_reg     <= '0;
      sdo_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.rx_valid && bus.rx_ready) begin
            rx_q         <= bus.rx_frame[74:0];
            bus.rx_ready <= 1'b0;
            state        <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (rx_q[74:64] == req_cob) begin
            sdo_cnt <= sdo_cnt + 16'd1;
            state   <= S_DECODE;
          end else begin
            bus.rx_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end
        S_DECODE: begin
          if (dec_adc) begin
            bus.adc_req <= 1'b1;
            bus.adc_ch  <= 5'(sub - 8'd1);
            tmo_cnt     <= '0;
            state       <= S_ADC_WAIT;
          end else begin
            if (dec_wr) user_reg <= wdata & wmask;
            bus.tx_frame <= mk_frame(node_id, dec_cmd, rx_q[55:32], dec_data);
            bus.tx_valid <= 1'b1;
            state        <= S_SEND;
          end
        end
        S_ADC_WAIT: begin
          // an ack in the expiry cycle is still honoured
          if (bus.adc_ack) begin
            bus.adc_req  <= 1'b0;
            bus.tx_frame <= mk_frame(node_id, 8'h43, rx_q[55:32], {20'h0, bus.adc_val});
            bus.tx_valid <= 1'b1;
            state        <= S_SEND;
          end else if (tmo_cnt == ADC_TIMEOUT - 16'd1) begin
            bus.adc_req  <= 1'b0;
            bus.tx_frame <= mk_frame(node_id, 8'h80, rx_q[55:32], ABORT_TIMEOUT);
            bus.tx_valid <= 1'b1;
            state        <= S_SEND;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            bus.rx_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          bus.rx_ready <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mops_sdo_responder.sv
// Directed and randomized checks of mops_sdo_responder against a behavioural
// object-dictionary model.
module tb_mops_sdo_responder;

  localparam logic [31:0] DEV     = 32'h0000_0191;
  localparam int          N_CH    = 32;
  localparam int          TIMEOUT = 1000;

  logic        clk_40_m = 1'b0;
  logic        rst;
  logic [6:0]  node_id;
  logic [31:0] user_reg;
  logic [15:0] sdo_cnt;

  mops_sdo_responder_if bus ();

  mops_sdo_responder #(
    .DEVICE_TYPE (DEV),
    .N_ADC_CH    (N_CH),
    .ADC_TIMEOUT (16'(TIMEOUT))
  ) dut (
    .clk_40_m (clk_40_m),
    .rst      (rst),
    .node_id  (node_id),
    .bus      (bus),
    .user_reg (user_reg),
    .sdo_cnt  (sdo_cnt)
  );

  always #5 clk_40_m = ~clk_40_m;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_user = '0;
  logic [15:0] m_cnt  = '0;

  task automatic tick();
    @(posedge clk_40_m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_bytes(input logic [7:0] c, input logic [15:0] ix,
                                             input logic [7:0] sb, input logic [31:0] d);
    logic [7:0]  b [8];
    logic [63:0] p;
    b[0] = c; b[1] = ix[7:0]; b[2] = ix[15:8]; b[3] = sb;
    for (int i = 0; i < 4; i++) b[4+i] = 8'(d >> (8*i));
    p = '0;
    for (int i = 0; i < 8; i++) p = {p[55:0], b[i]};
    return p;
  endfunction

  // Reference object dictionary: response command/data for one request.
  function automatic void ref_decode(input logic [7:0] c, input logic [15:0] ix,
                                     input logic [7:0] sb, input logic [31:0] d,
                                     output bit adc, output logic [7:0] rc,
                                     output logic [31:0] rd, output bit wr,
                                     output logic [31:0] wv);
    bit up, dn;
    int nb;
    up  = (c == 8'h40);
    dn  = (c == 8'h23) || (c == 8'h27) || (c == 8'h2B) || (c == 8'h2F);
    adc = 0; wr = 0; rc = 8'h80; rd = 32'h0602_0000; wv = '0;
    if (!up && !dn) rd = 32'h0504_0001;
    else if (up) begin
      case (ix)
        16'h1000: if (sb == 0) begin rc = 8'h43; rd = DEV; end
        16'h2200: if (sb == 0) begin rc = 8'h43; rd = m_user; end
        16'h2400: if (int'(sb) >= 1 && int'(sb) <= N_CH) adc = 1;
                  else rd = 32'h0609_0011;
        default: ;
      endcase
    end else begin
      case (ix)
        16'h1000, 16'h2400: rd = 32'h0601_0002;
        16'h2200: if (sb == 0) begin
          nb = 4 - int'(c[3:2]);
          rc = 8'h60; rd = '0; wr = 1;
          wv = 32'(64'(d) & ((64'd1 << (8*nb)) - 64'd1));
        end
        default: ;
      endcase
    end
  endfunction

  task automatic run_txn(input string tag, input logic [75:0] f, input int ack_after,
                         input logic [11:0] av, input int exp_lat,
                         input logic [75:0] exp_f, input int stall);
    int n, req_cycles;
    bit stable;
    chk({tag, "/rx_ready_idle"}, 76'(bus.rx_ready), 76'(1));
    bus.rx_frame = f; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0; bus.rx_frame = {$urandom, $urandom, $urandom};
    n = 0; req_cycles = 0;
    while (!bus.tx_valid && n < 3000) begin
      if (bus.adc_req) begin
        req_cycles++;
        if (req_cycles == 1)
          chk({tag, "/adc_ch"}, 76'(bus.adc_ch), 76'(5'(f[39:32] - 8'd1)));
        if (ack_after >= 0 && req_cycles == ack_after) begin
          bus.adc_ack = 1'b1; bus.adc_val = av;
        end
      end
      tick();
      bus.adc_ack = 1'b0; bus.adc_val = 12'($urandom);
      n++;
    end
    chk({tag, "/latency"}, 76'(n), 76'(exp_lat));
    chk({tag, "/frame"}, bus.tx_frame, exp_f);
    chk({tag, "/adc_req_off"}, 76'(bus.adc_req), 76'(0));
    if (stall > 0) begin
      stable = 1;
      repeat (stall) begin
        tick();
        if (bus.tx_frame !== exp_f || bus.tx_valid !== 1'b1 || bus.rx_ready !== 1'b0) stable = 0;
      end
      chk({tag, "/stall_stable"}, 76'(stable), 76'(1));
    end
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    chk({tag, "/tx_valid_done"}, 76'(bus.tx_valid), 76'(0));
    chk({tag, "/rx_ready_done"}, 76'(bus.rx_ready), 76'(1));
  endtask

  task automatic model_txn(input string tag, input logic [7:0] c, input logic [15:0] ix,
                           input logic [7:0] sb, input logic [31:0] d, input bit b75,
                           input int ack_after, input logic [11:0] av, input int stall);
    bit adc, wr;
    logic [7:0]  rc;
    logic [31:0] rd, wv;
    logic [75:0] f;
    int lat;
    ref_decode(c, ix, sb, d, adc, rc, rd, wr, wv);
    f = {b75, 11'h600 + 11'(node_id), pack_bytes(c, ix, sb, d)};
    m_cnt = m_cnt + 16'd1;
    lat = 2;
    if (adc && ack_after < 0) begin rc = 8'h80; rd = 32'h0800_0000; lat = 2 + TIMEOUT; end
    else if (adc) begin rc = 8'h43; rd = {20'h0, av}; lat = 2 + ack_after; end
    if (wr) m_user = wv;
    run_txn(tag, f, adc ? ack_after : -1, av, lat,
            {1'b0, 11'h580 + 11'(node_id), pack_bytes(rc, ix, sb, rd)}, stall);
    chk({tag, "/sdo_cnt"}, 76'(sdo_cnt), 76'(m_cnt));
    chk({tag, "/user_reg"}, 76'(user_reg), 76'(m_user));
  endtask

  task automatic run_filtered(input string tag, input logic [75:0] f);
    bit any_tx;
    any_tx = 0;
    chk({tag, "/rx_ready_idle"}, 76'(bus.rx_ready), 76'(1));
    bus.rx_frame = f; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    chk({tag, "/rx_ready_drop"}, 76'(bus.rx_ready), 76'(0));
    repeat (2) begin if (bus.tx_valid) any_tx = 1; tick(); end
    chk({tag, "/rx_ready_back"}, 76'(bus.rx_ready), 76'(1));
    repeat (4) begin if (bus.tx_valid) any_tx = 1; tick(); end
    chk({tag, "/no_tx"}, 76'(any_tx), 76'(0));
    chk({tag, "/sdo_cnt"}, 76'(sdo_cnt), 76'(m_cnt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/rx_ready"}, 76'(bus.rx_ready), 76'(1));
    chk({tag, "/tx_valid"}, 76'(bus.tx_valid), 76'(0));
    chk({tag, "/tx_frame"}, bus.tx_frame, 76'(0));
    chk({tag, "/adc_req"},  76'(bus.adc_req), 76'(0));
    chk({tag, "/adc_ch"},   76'(bus.adc_ch), 76'(0));
    chk({tag, "/user_reg"}, 76'(user_reg), 76'(0));
    chk({tag, "/sdo_cnt"},  76'(sdo_cnt), 76'(0));
  endtask

  initial begin
    logic [7:0]  cmd_tab [7];
    logic [15:0] idx_tab [5];
    logic [7:0]  c, sb;
    logic [15:0] ix;
    logic [10:0] bad_cob;
    int          waitn;
    bit          any_tx;

    cmd_tab = '{8'h40, 8'h40, 8'h23, 8'h27, 8'h2B, 8'h2F, 8'h00};
    idx_tab = '{16'h1000, 16'h2200, 16'h2400, 16'h2400, 16'h0000};

    rst = 1'b0; node_id = 7'h05;
    bus.rx_frame = '0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    bus.adc_ack = 1'b0; bus.adc_val = '0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b1;
    tick();

    model_txn("up_1000", 8'h40, 16'h1000, 8'h00, 32'h0, 1'b0, -1, 12'h0, 0);
    chk("up_1000/frame_literal", 76'(pack_bytes(8'h43, 16'h1000, 8'h00, DEV)),
        76'(64'h4300_1000_9101_0000));
    model_txn("dn_2b_2200", 8'h2B, 16'h2200, 8'h00, 32'h1234_BEEF, 1'b0, -1, 12'h0, 0);
    chk("dn_2b_2200/user_reg_lit", 76'(user_reg), 76'(32'h0000_BEEF));
    model_txn("up_2200", 8'h40, 16'h2200, 8'h00, 32'h0, 1'b0, -1, 12'h0, 0);
    model_txn("adc_ack10", 8'h40, 16'h2400, 8'h03, 32'h0, 1'b0, 10, 12'hABC, 0);
    model_txn("adc_timeout", 8'h40, 16'h2400, 8'h03, 32'h0, 1'b0, -1, 12'h0, 0);
    model_txn("adc_sub21", 8'h40, 16'h2400, 8'h21, 32'h0, 1'b0, -1, 12'h0, 0);
    model_txn("adc_sub0", 8'h40, 16'h2400, 8'h00, 32'h0, 1'b0, -1, 12'h0, 0);
    model_txn("adc_sub20", 8'h40, 16'h2400, 8'h20, 32'h0, 1'b0, 1, 12'hFFF, 0);
    run_filtered("cob_606", {1'b0, 11'h606, pack_bytes(8'h40, 16'h1000, 8'h00, 32'h0)});
    model_txn("cmd_55", 8'h55, 16'h1000, 8'h00, 32'h0, 1'b0, -1, 12'h0, 0);
    model_txn("dn_1000", 8'h23, 16'h1000, 8'h00, 32'hFFFF_FFFF, 1'b0, -1, 12'h0, 0);
    model_txn("stall50", 8'h40, 16'h1000, 8'h00, 32'h0, 1'b1, -1, 12'h0, 50);

    // reset pulse while waiting on the ADC
    bus.rx_frame = {1'b0, 11'h605, pack_bytes(8'h40, 16'h2400, 8'h05, 32'h0)};
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    waitn = 0;
    while (!bus.adc_req && waitn < 10) begin tick(); waitn++; end
    chk("rst_mid/adc_req_seen", 76'(bus.adc_req), 76'(1));
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_reset_vals("rst_mid");
    m_user = '0; m_cnt = '0;
    any_tx = 0;
    bus.adc_ack = 1'b1; bus.adc_val = 12'h123;
    tick();
    bus.adc_ack = 1'b0;
    repeat (20) begin if (bus.tx_valid || bus.adc_req) any_tx = 1; tick(); end
    chk("rst_mid/no_response", 76'(any_tx), 76'(0));

    node_id = 7'h7F;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        bad_cob = 11'($urandom);
        if (bad_cob == 11'h600 + 11'(node_id)) bad_cob = bad_cob ^ 11'h001;
        run_filtered("rnd_filt", {1'(bit'($urandom)), bad_cob,
                                  pack_bytes(8'h40, 16'h1000, 8'h00, 32'h0)});
      end else begin
        c  = cmd_tab[$urandom_range(0, 6)];
        if (c == 8'h00) c = 8'($urandom);
        ix = idx_tab[$urandom_range(0, 4)];
        if (ix == 16'h0000) ix = 16'($urandom);
        sb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'h00;
        if (ix == 16'h2400 && c == 8'h40 && sb == 8'h00 && $urandom_range(0, 1) == 1)
          sb = 8'($urandom_range(1, 32));
        model_txn("rnd", c, ix, sb, $urandom, 1'(bit'($urandom)),
                  int'($urandom_range(1, 15)), 12'($urandom), int'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
